// File: rtl/comparator_magnitude_multicycle_if.sv
// Operand/result bundle for the multi-cycle magnitude comparator.
// The master issues requests and the slave returns busy/done plus result flags.
interface comparator_magnitude_multicycle_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             A_greater_than_B;
    logic             A_equal_B;
    logic             A_less_than_B;

    modport master (
        output start, is_signed, A, B,
        input  busy, done, A_greater_than_B, A_equal_B, A_less_than_B
    );

    modport slave (
        input  start, is_signed, A, B,
        output busy, done, A_greater_than_B, A_equal_B, A_less_than_B
    );
endinterface

// File: rtl/comparator_magnitude_multicycle.sv
// Magnitude comparator that walks the operands DIGIT bits per cycle, MSB first,
// and stops at the first differing digit.
//
// state   | meaning
// IDLE    | waiting for start
// COMPARE | comparing one digit per cycle
// DONE    | one-cycle result pulse; start here is accepted back-to-back
module comparator_magnitude_multicycle #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic clk,
    input  logic reset,
    comparator_magnitude_multicycle_if.slave bus
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(NDIG + 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [WIDTH-1:0] sign_mask;

    assign a_dig     = a_q[WIDTH-1 -: DIGIT];
    assign b_dig     = b_q[WIDTH-1 -: DIGIT];
    // Flipping the sign bit maps two's complement onto offset binary.
    assign sign_mask = bus.is_signed ? MSB_MASK : '0;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_d     = bus.A ^ sign_mask;
                    b_d     = bus.B ^ sign_mask;
                    cnt_d   = CNT_W'(NDIG);
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (a_dig != b_dig) begin
                    gt_d    = (a_dig > b_dig);
                    lt_d    = (a_dig < b_dig);
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(1)) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    a_d   = a_q << DIGIT;
                    b_d   = b_q << DIGIT;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign bus.busy             = (state_q == COMPARE);
    assign bus.done             = (state_q == DONE);
    assign bus.A_greater_than_B = gt_q;
    assign bus.A_equal_B        = eq_q;
    assign bus.A_less_than_B    = lt_q;
endmodule

// File: tb/tb_comparator_magnitude_multicycle.sv
// Scoreboard bench for the multi-cycle comparator: directed scenarios plus random
// operands, checked against an arithmetic reference model.
module tb_comparator_magnitude_multicycle;
    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int NDIG  = WIDTH / DIGIT;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        logic [2:0] flags;     // {gt, eq, lt}
        int         done_cyc;
    } exp_t;
    exp_t exp_q[$];

    comparator_magnitude_multicycle_if #(.WIDTH(WIDTH)) bus ();

    comparator_magnitude_multicycle #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d (time %0t)", name, act, exp, $time);
        end
    endtask

    // Reference: ordinary integer compare; latency from the highest differing bit.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic s, output logic [2:0] flags, output int k);
        int ai, bi, msb;
        ai = s ? int'($signed(a)) : int'(a);
        bi = s ? int'($signed(b)) : int'(b);
        flags = {ai > bi, ai == bi, ai < bi};
        msb = -1;
        for (int i = 0; i < WIDTH; i++)
            if (a[i] != b[i]) msb = i;
        k = (msb < 0) ? NDIG : ((WIDTH - 1 - msb) / DIGIT + 1);
    endfunction

    task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic s, input int accept_cyc);
        exp_t e;
        int   k;
        model(a, b, s, e.flags, k);
        e.done_cyc = accept_cyc + k;
        exp_q.push_back(e);
    endtask

    function automatic logic [2:0] flags_now();
        return {bus.A_greater_than_B, bus.A_equal_B, bus.A_less_than_B};
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_flags", int'(flags_now()), int'(e.flags));
                chk("done_cycle", cyc, e.done_cyc);
                chk("busy_low_at_done", int'(bus.busy), 0);
            end
        end
    end

    // Drive a one-cycle start; on return we sit at the negedge after the accept edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input bit expect_result);
        @(negedge clk);
        bus.A = a; bus.B = b; bus.is_signed = s; bus.start = 1'b1;
        if (expect_result) push_exp(a, b, s, cyc + 1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_accept", int'(bus.busy), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || bus.done) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("idle_timeout", n, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        n_checks = 0; n_fail = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_flags", int'(flags_now()), 0);
        reset = 1'b0;

        // Unsigned early exit, then flags must hold in IDLE.
        issue(8'hC3, 8'h3C, 1'b0, 1'b1);
        wait_idle();
        @(negedge clk);
        chk("flags_hold", int'(flags_now()), 3'b100);

        // Equality / full latency, then LT at last digit.
        issue(8'h5A, 8'h5A, 1'b0, 1'b1); wait_idle();
        issue(8'h12, 8'h13, 1'b0, 1'b1); wait_idle();

        // Signed vs unsigned.
        issue(8'h80, 8'h7F, 1'b1, 1'b1); wait_idle();
        issue(8'h80, 8'h7F, 1'b0, 1'b1); wait_idle();
        issue(8'hFF, 8'hFE, 1'b1, 1'b1); wait_idle();

        // Start during COMPARE is ignored.
        issue(8'h00, 8'h01, 1'b0, 1'b1);
        @(negedge clk);
        bus.start = 1'b1; bus.A = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("no_second_op_busy", int'(bus.busy), 0);

        // Reset mid-operation at E2.
        issue(8'hAA, 8'hAA, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_flags", int'(flags_now()), 0);
        repeat (5) @(negedge clk);
        issue(8'h01, 8'h00, 1'b0, 1'b1); wait_idle();

        // Reset and start together: reset wins.
        @(negedge clk);
        bus.start = 1'b1; reset = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; reset = 1'b0;
        chk("reset_beats_start", int'(bus.busy), 0);

        // Back-to-back with start held high.
        @(negedge clk);
        bus.A = 8'hF0; bus.B = 8'h0F; bus.is_signed = 1'b0; bus.start = 1'b1;
        push_exp(8'hF0, 8'h0F, 1'b0, cyc + 1);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_done_pulse", int'(bus.done), 1);
        bus.A = 8'h0F; bus.B = 8'hF0;
        push_exp(8'h0F, 8'hF0, 1'b0, cyc + 1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_done_drops", int'(bus.done), 0);
        chk("b2b_busy_rises", int'(bus.busy), 1);
        wait_idle();

        // Random operands, biased toward long common prefixes.
        for (int i = 0; i < 60; i++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default: rb = WIDTH'($urandom);
            endcase
            issue(ra, rb, 1'($urandom), 1'b1);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
